// File: rtl/clap_pkg.sv
// Shared definitions for the clap light controller slice.
// No logic of its own: constants, FSM encodings and a width helper.
// Imported by the controller top and the per-light auto-off timer.
package clap_pkg;

   // Event codes reported alongside each accepted nonzero command
   localparam logic [1:0] EVT_TOGGLE  = 2'd0;
   localparam logic [1:0] EVT_ALL_OFF = 2'd1;
   localparam logic [1:0] EVT_ALL_ON  = 2'd2;
   localparam logic [1:0] EVT_INVALID = 2'd3;

   // Controller FSM encodings
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_APPLY   = 2'd1;
   localparam logic [1:0] ST_LOCKOUT = 2'd2;

   // Bits needed to hold values 0..value-1; never less than one bit so that
   // degenerate parameter choices still produce a legal vector width.
   function automatic int clogb2(input int value);
      int width;
      width = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) begin
            width = i + 1;
         end
      end
      return (width < 1) ? 1 : width;
   endfunction

endpackage

// File: rtl/auto_off_timer.sv
// One light channel: holds the light bit and its optional auto-off countdown.
// Latency: command applied on the edge it is presented; expiry clears the light
// AUTO_OFF_CYCLES edges after it turned on. No backpressure; a command always wins.
module auto_off_timer
   import clap_pkg::*;
#(
   parameter int AUTO_OFF_CYCLES = 0
) (
   input  logic clock,
   input  logic reset,
   input  logic cmd_en,
   input  logic cmd_val,
   output logic light
);

   if (AUTO_OFF_CYCLES > 0) begin : g_timer
      localparam int CW = clogb2(AUTO_OFF_CYCLES + 1);
      localparam logic [CW-1:0] LOAD = CW'(AUTO_OFF_CYCLES);

      // The counter holds the number of edges left before the light self-clears.
      logic [CW-1:0] remain;

      // Command has priority; otherwise an on light counts down and clears at 1.
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            light  <= 1'b0;
            remain <= '0;
         end else if (cmd_en) begin
            light <= cmd_val;
            // Any command that lights a dark channel restarts its on-time
            if (cmd_val && !light) begin
               remain <= LOAD;
            end
         end else if (light) begin
            if (remain == CW'(1)) begin
               light <= 1'b0;
            end
            remain <= remain - CW'(1);
         end
      end
   end else begin : g_plain
      // Without a timer the light only changes on commands.
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            light <= 1'b0;
         end else if (cmd_en) begin
            light <= cmd_val;
         end
      end
   end

endmodule

// File: rtl/clap_light_controller.sv
// Multi-channel light controller driven by clap-burst counts.
// Latency: lights and event update one edge after the accept edge.
// Backpressure: claps_ready low during the apply cycle and the post-command lockout.
module clap_light_controller
   import clap_pkg::*;
#(
   parameter int CLAPS_IN_WIDTH  = 16,
   parameter int NUM_LIGHTS      = 4,
   parameter int ALL_CLAPS       = 8,
   parameter int LOCKOUT_CYCLES  = 50000000,
   parameter int AUTO_OFF_CYCLES = 0,
   parameter int INDEX_WIDTH     = clogb2(NUM_LIGHTS)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [CLAPS_IN_WIDTH-1:0] claps_data,
   input  logic                      claps_valid,
   output logic                      claps_ready,
   output logic [NUM_LIGHTS-1:0]     light_state,
   output logic                      event_valid,
   output logic [1:0]                event_code,
   output logic [INDEX_WIDTH-1:0]    event_index
);

   localparam int LOCK_W = clogb2(LOCKOUT_CYCLES);
   localparam logic [LOCK_W-1:0] LOCK_LOAD =
      (LOCKOUT_CYCLES > 0) ? LOCK_W'(LOCKOUT_CYCLES - 1) : '0;
   localparam logic [CLAPS_IN_WIDTH-1:0] ALL_COUNT = CLAPS_IN_WIDTH'(ALL_CLAPS);

   logic [1:0]                state_q;
   logic [CLAPS_IN_WIDTH-1:0] count_q;
   logic [LOCK_W-1:0]         lock_q;

   logic                      apply;
   logic                      lights_off;
   logic                      dec_evt;
   logic [NUM_LIGHTS-1:0]     dec_en;
   logic [NUM_LIGHTS-1:0]     dec_val;
   logic [1:0]                dec_code;
   logic [INDEX_WIDTH-1:0]    dec_idx;

   assign apply      = (state_q == ST_APPLY);
   assign lights_off = (light_state == '0);

   // Decode the captured count into per-light commands and an event report.
   always_comb begin
      dec_en   = '0;
      dec_val  = '0;
      dec_code = EVT_INVALID;
      dec_idx  = '0;
      dec_evt  = (count_q != '0);
      if (count_q == ALL_COUNT) begin
         // All-off wins whenever anything is lit; all-on only from fully dark
         dec_en   = '1;
         dec_val  = {NUM_LIGHTS{lights_off}};
         dec_code = lights_off ? EVT_ALL_ON : EVT_ALL_OFF;
      end else begin
         for (int i = 0; i < NUM_LIGHTS; i++) begin
            if (count_q == CLAPS_IN_WIDTH'(i + 1)) begin
               dec_en[i]  = 1'b1;
               dec_val[i] = ~light_state[i];
               dec_code   = EVT_TOGGLE;
               dec_idx    = INDEX_WIDTH'(i);
            end
         end
      end
   end

   // Accept, apply and lockout sequencing with registered ready and event outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         lock_q      <= '0;
         claps_ready <= 1'b0;
         event_valid <= 1'b0;
         event_code  <= 2'd0;
         event_index <= '0;
      end else begin
         event_valid <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (claps_valid && claps_ready) begin
                  count_q     <= claps_data;
                  state_q     <= ST_APPLY;
                  claps_ready <= 1'b0;
               end else begin
                  claps_ready <= 1'b1;
               end
            end
            ST_APPLY: begin
               if (dec_evt) begin
                  event_valid <= 1'b1;
                  event_code  <= dec_code;
                  event_index <= dec_idx;
                  if (LOCKOUT_CYCLES == 0) begin
                     state_q     <= ST_IDLE;
                     claps_ready <= 1'b1;
                  end else begin
                     state_q <= ST_LOCKOUT;
                     lock_q  <= LOCK_LOAD;
                  end
               end else begin
                  // A zero count is silence, not a command: no echo guard needed
                  state_q     <= ST_IDLE;
                  claps_ready <= 1'b1;
               end
            end
            ST_LOCKOUT: begin
               // Counter parks at zero; the final lockout cycle reopens the input
               if (lock_q == '0) begin
                  state_q     <= ST_IDLE;
                  claps_ready <= 1'b1;
               end else begin
                  lock_q <= lock_q - LOCK_W'(1);
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               claps_ready <= 1'b0;
            end
         endcase
      end
   end

   // One light channel per output bit; each owns its bit and timer.
   for (genvar g = 0; g < NUM_LIGHTS; g++) begin : g_light
      auto_off_timer #(
         .AUTO_OFF_CYCLES(AUTO_OFF_CYCLES)
      ) u_timer (
         .clock   (clock),
         .reset   (reset),
         .cmd_en  (dec_en[g] & apply),
         .cmd_val (dec_val[g]),
         .light   (light_state[g])
      );
   end

endmodule

// File: tb/tb_clap_light_controller.sv
// Self-checking bench for clap_light_controller against a time-stamped model.
// Model tracks on-edge per light and the edge after which ready returns.
// Directed scenarios followed by randomized bursts with random idle gaps.
module tb_clap_light_controller;

   localparam int NL = 4;
   localparam int AC = 8;
   localparam int LC = 16;
   localparam int AO = 100;
   localparam int CW = 16;
   localparam int IW = 2;

   logic          clock = 1'b0;
   logic          reset;
   logic [CW-1:0] claps_data;
   logic          claps_valid;
   logic          claps_ready;
   logic [NL-1:0] light_state;
   logic          event_valid;
   logic [1:0]    event_code;
   logic [IW-1:0] event_index;

   clap_light_controller #(
      .CLAPS_IN_WIDTH (CW),
      .NUM_LIGHTS     (NL),
      .ALL_CLAPS      (AC),
      .LOCKOUT_CYCLES (LC),
      .AUTO_OFF_CYCLES(AO),
      .INDEX_WIDTH    (IW)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .claps_data  (claps_data),
      .claps_valid (claps_valid),
      .claps_ready (claps_ready),
      .light_state (light_state),
      .event_valid (event_valid),
      .event_code  (event_code),
      .event_index (event_index)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // Model: a light is lit at edge n if it was switched on at m_on_edge and
   // n is before m_on_edge + AO (auto-off expiry).
   bit         m_on[NL];
   int         m_on_edge[NL];
   int         m_ready_at = 1 << 30;
   logic [1:0] m_code;
   logic [IW-1:0] m_idx;

   function automatic logic [NL-1:0] lit_vec(input int n);
      logic [NL-1:0] v;
      for (int i = 0; i < NL; i++) v[i] = m_on[i] && (n < m_on_edge[i] + AO);
      return v;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NL; i++) begin
         m_on[i] = 1'b0;
         m_on_edge[i] = 0;
      end
      m_code = 2'd0;
      m_idx  = '0;
   endtask

   // Present count c (not before edge at_edge), then verify the response.
   // Returns the accept edge number in e0 (-1 if never accepted).
   task automatic do_send(input int c, input int at_edge, output int e0);
      logic [NL-1:0] prev;
      bit has_evt;
      bit acc;
      acc = 1'b0;
      e0 = -1;
      for (int k = 0; k < 600; k++) begin
         checks++;
         if (light_state !== lit_vec(cyc)) begin
            errors++;
            $display("FAIL wait_light cyc=%0d got %b expected %b", cyc, light_state, lit_vec(cyc));
         end
         checks++;
         if (claps_ready !== (cyc >= m_ready_at)) begin
            errors++;
            $display("FAIL wait_ready cyc=%0d got %b expected %b", cyc, claps_ready, (cyc >= m_ready_at));
         end
         if (cyc >= at_edge - 1) begin
            claps_valid = 1'b1;
            claps_data  = CW'(c);
         end
         if (claps_valid && claps_ready) begin
            acc = 1'b1;
            break;
         end
         @(negedge clock);
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout count=%0d got not-accepted expected accepted", c);
         claps_valid = 1'b0;
         return;
      end
      @(negedge clock);
      e0 = cyc;
      claps_valid = 1'b0;
      checks++;
      if (claps_ready !== 1'b0) begin
         errors++;
         $display("FAIL apply_ready got %b expected 0", claps_ready);
      end
      checks++;
      if (light_state !== lit_vec(e0)) begin
         errors++;
         $display("FAIL apply_light got %b expected %b", light_state, lit_vec(e0));
      end
      checks++;
      if (event_valid !== 1'b0) begin
         errors++;
         $display("FAIL apply_evt got %b expected 0", event_valid);
      end
      // Model update for the command landing at edge e0+1
      prev = lit_vec(e0);
      has_evt = (c != 0);
      if (c >= 1 && c <= NL) begin
         m_on[c-1] = !prev[c-1];
         m_on_edge[c-1] = e0 + 1;
         m_code = 2'd0;
         m_idx = IW'(c - 1);
      end else if (c == AC) begin
         for (int i = 0; i < NL; i++) begin
            m_on[i] = (prev == '0);
            m_on_edge[i] = e0 + 1;
         end
         m_code = (prev == '0) ? 2'd2 : 2'd1;
         m_idx = '0;
      end else if (c != 0) begin
         m_code = 2'd3;
         m_idx = '0;
      end
      m_ready_at = (c == 0) ? e0 + 1 : e0 + 1 + LC;
      @(negedge clock);
      checks++;
      if (light_state !== lit_vec(cyc)) begin
         errors++;
         $display("FAIL e1_light count=%0d got %b expected %b", c, light_state, lit_vec(cyc));
      end
      checks++;
      if (event_valid !== has_evt) begin
         errors++;
         $display("FAIL e1_evt count=%0d got %b expected %b", c, event_valid, has_evt);
      end
      checks++;
      if (event_code !== m_code || event_index !== m_idx) begin
         errors++;
         $display("FAIL e1_code count=%0d got %0d/%0d expected %0d/%0d", c, event_code, event_index, m_code, m_idx);
      end
      checks++;
      if (claps_ready !== (cyc >= m_ready_at)) begin
         errors++;
         $display("FAIL e1_ready count=%0d got %b expected %b", c, claps_ready, (cyc >= m_ready_at));
      end
      @(negedge clock);
      checks++;
      if (event_valid !== 1'b0) begin
         errors++;
         $display("FAIL evt_pulse count=%0d got %b expected 0", c, event_valid);
      end
      checks++;
      if (event_code !== m_code || event_index !== m_idx) begin
         errors++;
         $display("FAIL code_hold got %0d/%0d expected %0d/%0d", event_code, event_index, m_code, m_idx);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      claps_valid = 1'b0;
      claps_data = '0;
      model_clear();
      repeat (3) begin
         @(negedge clock);
         checks++;
         if (light_state !== '0 || claps_ready !== 1'b0 || event_valid !== 1'b0 ||
             event_code !== 2'd0 || event_index !== '0) begin
            errors++;
            $display("FAIL reset_outputs got light=%b rdy=%b ev=%b code=%0d idx=%0d expected all 0",
                     light_state, claps_ready, event_valid, event_code, event_index);
         end
      end
      reset = 1'b0;
      m_ready_at = cyc + 1;
      #1;
      checks++;
      if (claps_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_ready got %b expected 0", claps_ready);
      end
      @(negedge clock);
      checks++;
      if (claps_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_release got %b expected 1", claps_ready);
      end
   endtask

   task automatic test_toggle();
      int e0;
      int low;
      do_send(3, 0, e0);
      checks++;
      if (light_state !== 4'b0100 || event_code !== 2'd0 || event_index !== 2'd2) begin
         errors++;
         $display("FAIL toggle3 got %b/%0d/%0d expected 0100/0/2", light_state, event_code, event_index);
      end
      // Ready was low from the accept edge; count low cycles until it returns
      low = cyc - e0;
      for (int k = 0; k < 40 && claps_ready !== 1'b1; k++) begin
         @(negedge clock);
         low++;
      end
      checks++;
      if (low !== 17) begin
         errors++;
         $display("FAIL toggle_lockout_len got %0d expected 17", low);
      end
      do_send(3, 0, e0);
      checks++;
      if (light_state !== 4'b0000) begin
         errors++;
         $display("FAIL toggle3_again got %b expected 0000", light_state);
      end
   endtask

   task automatic test_all();
      int e0;
      do_send(AC, 0, e0);
      checks++;
      if (light_state !== 4'b1111 || event_code !== 2'd2) begin
         errors++;
         $display("FAIL all_on got %b/%0d expected 1111/2", light_state, event_code);
      end
      do_send(AC, 0, e0);
      checks++;
      if (light_state !== 4'b0000 || event_code !== 2'd1) begin
         errors++;
         $display("FAIL all_off got %b/%0d expected 0000/1", light_state, event_code);
      end
      do_send(5, 0, e0);
      checks++;
      if (light_state !== 4'b0000 || event_code !== 2'd3 || event_index !== 2'd0 || claps_ready !== 1'b0) begin
         errors++;
         $display("FAIL invalid5 got %b/%0d/%0d rdy=%b expected 0000/3/0 rdy=0",
                  light_state, event_code, event_index, claps_ready);
      end
   endtask

   task automatic test_zero_lockout();
      int e0;
      int e0b;
      do_send(0, 0, e0);
      checks++;
      if (claps_ready !== 1'b1 || event_code !== 2'd3) begin
         errors++;
         $display("FAIL zero_count got rdy=%b code=%0d expected rdy=1 code=3", claps_ready, event_code);
      end
      do_send(6, 0, e0);
      // Hold a pending count of 1 through the lockout
      claps_valid = 1'b1;
      claps_data = 16'd1;
      for (int k = 0; k < 40 && cyc < e0 + 17; k++) begin
         @(negedge clock);
         checks++;
         if (claps_ready !== (cyc >= e0 + 17)) begin
            errors++;
            $display("FAIL hold_ready cyc=%0d got %b expected %b", cyc - e0, claps_ready, (cyc >= e0 + 17));
         end
      end
      do_send(1, 0, e0b);
      checks++;
      if (e0b !== e0 + 18 || light_state[0] !== 1'b1 || event_index !== 2'd0) begin
         errors++;
         $display("FAIL held_accept got edge=%0d light0=%b expected edge=%0d light0=1",
                  e0b - e0, light_state[0], 18);
      end
   endtask

   task automatic test_auto_off();
      int e0;
      int e1;
      int e0b;
      logic [NL-1:0] now;
      now = lit_vec(cyc);
      if (now[0]) do_send(1, 0, e0);
      do_send(1, 0, e0);
      e1 = e0 + 1;
      for (int k = 0; k < 200 && cyc < e1 + 100; k++) begin
         @(negedge clock);
         checks++;
         if (event_valid !== 1'b0) begin
            errors++;
            $display("FAIL autooff_event cyc=%0d got %b expected 0", cyc - e1, event_valid);
         end
         if (cyc == e1 + 99) begin
            checks++;
            if (light_state[0] !== 1'b1) begin
               errors++;
               $display("FAIL autooff_early got %b expected 1", light_state[0]);
            end
         end
      end
      checks++;
      if (cyc !== e1 + 100 || light_state[0] !== 1'b0) begin
         errors++;
         $display("FAIL autooff_expire at=%0d got %b expected 0 at 100", cyc - e1, light_state[0]);
      end
      // Toggle-off landing on the expiry edge
      do_send(1, 0, e0);
      e1 = e0 + 1;
      do_send(1, e1 + 99, e0b);
      checks++;
      if (e0b !== e1 + 99 || light_state[0] !== 1'b0 || event_code !== 2'd0) begin
         errors++;
         $display("FAIL collision got edge=%0d light0=%b code=%0d expected edge=99 light0=0 code=0",
                  e0b - e1, light_state[0], event_code);
      end
      repeat (3) @(negedge clock);
      checks++;
      if (light_state[0] !== 1'b0) begin
         errors++;
         $display("FAIL collision_stays got %b expected 0", light_state[0]);
      end
   endtask

   task automatic test_async_reset();
      int e0;
      do_send(2, 0, e0);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (light_state !== '0 || claps_ready !== 1'b0 || event_code !== 2'd0) begin
         errors++;
         $display("FAIL async_reset got light=%b rdy=%b code=%0d expected 0/0/0", light_state, claps_ready, event_code);
      end
      model_clear();
      @(negedge clock);
      reset = 1'b0;
      m_ready_at = cyc + 1;
      @(negedge clock);
      checks++;
      if (claps_ready !== 1'b1 || light_state !== '0) begin
         errors++;
         $display("FAIL after_async_reset got rdy=%b light=%b expected 1/0000", claps_ready, light_state);
      end
      do_send(2, 0, e0);
      checks++;
      if (light_state !== 4'b0010 || event_index !== 2'd1) begin
         errors++;
         $display("FAIL resume got %b/%0d expected 0010/1", light_state, event_index);
      end
   endtask

   task automatic test_random();
      int e0;
      int c;
      int r;
      for (int n = 0; n < 30; n++) begin
         r = $urandom_range(0, 9);
         c = (r == 9) ? $urandom_range(AC + 1, 65535) : r;
         do_send(c, cyc + $urandom_range(0, 130), e0);
      end
   endtask

   initial begin
      test_reset();
      test_toggle();
      test_all();
      test_zero_lockout();
      test_auto_off();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
